// File: rtl/dm_responder.sv
// Data-memory responder: slave end of the M-stage request/response interface.
// One request at a time, serviced LATENCY edges after the handshake, then a one-cycle response pulse.
module dm_responder #(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic [31:0] mem_q [DEPTH];
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic [31:0]       word_off_d;
  logic [ADDR_W-1:0] idx_d;
  logic              acc_err_d;
  logic [31:0]       merged_d;

  // Address decode and byte-lane merge for the latched request.
  always_comb begin
    word_off_d = (addr_q - BASE) >> 2;
    idx_d      = word_off_d[ADDR_W-1:0];
    acc_err_d  = ((word_off_d >> ADDR_W) != 32'd0) || (we_q && (be_q == 4'b0000));
    merged_d   = mem_q[idx_d];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged_d[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  assign req_ready = (state_q == IDLE) && reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      pc_q        <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      // NOTE: clearing every word on reset makes this array flops, not a RAM macro; that is intended here.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            pc_q    <= req_pc;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err_d;
            rsp_rdata_q <= (acc_err_d || we_q) ? 32'd0 : mem_q[idx_d];
            if (!acc_err_d && we_q) begin
              mem_q[idx_d] <= merged_d;
`ifndef SYNTHESIS
              $display("@%h: *%h <= %h", pc_q, addr_q & ~32'd3, merged_d);
`endif
            end
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a transaction-level model checked every cycle,
// plus directed requests with hand-computed expectations.
module tb_dm_responder;

  localparam int unsigned ADDR_W  = 12;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] req_pc = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec = 0;
  int n_err = 0;

  dm_responder #(.ADDR_W(ADDR_W), .BASE(BASE), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] m_mem [int unsigned];
  bit          m_live = 0;
  bit          m_pending = 0;
  bit          m_valid = 0;
  bit          m_err = 0;
  logic [31:0] m_rdata = 32'd0;
  int          m_edges_left = 0;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;

  function automatic logic [31:0] m_read(input int unsigned idx);
    return m_mem.exists(idx) ? m_mem[idx] : 32'd0;
  endfunction

  task automatic m_serve();
    int unsigned idx;
    logic [31:0] w;
    idx = (m_addr - BASE) >> 2;
    m_err   = (idx >= (32'd1 << ADDR_W)) || (m_we && m_be == 4'b0000);
    m_rdata = 32'd0;
    if (!m_err && m_we) begin
      w = m_read(idx);
      for (int i = 0; i < 4; i++) if (m_be[i]) w[8*i +: 8] = m_wdata[8*i +: 8];
      m_mem[idx] = w;
    end else if (!m_err) begin
      m_rdata = m_read(idx);
    end
  endtask

  initial forever begin
    @(posedge clk);
    m_live = 1;
    if (!reset) begin
      m_mem.delete();
      m_pending = 0; m_valid = 0; m_err = 0; m_rdata = 32'd0;
    end else if (m_valid) begin
      m_valid = 0; m_err = 0;
    end else if (m_pending) begin
      m_edges_left--;
      if (m_edges_left == 0) begin
        m_serve();
        m_pending = 0;
        m_valid = 1;
      end
    end else if (req_valid) begin
      m_we = req_we; m_addr = req_addr; m_be = req_be; m_wdata = req_wdata;
      m_pending = 1;
      m_edges_left = LATENCY;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, reset && !m_pending && !m_valid});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      check("rsp_err",   {31'd0, rsp_err},   {31'd0, m_err});
      check("rsp_rdata", rsp_rdata, m_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] pc,
                        output logic [31:0] rd, output logic err, output int lat);
    bit hs = 0;
    bit got = 0;
    rd = 32'd0; err = 1'b0; lat = 0;
    req_we = we; req_addr = addr; req_be = be; req_wdata = wd; req_pc = pc; req_valid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      if (req_ready) hs = 1;
    end
    check("handshake_seen", {31'd0, hs}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_be = 4'($urandom);
    req_wdata = $urandom; req_pc = $urandom;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        got = 1; rd = rsp_rdata; err = rsp_err;
      end
    end
    check("response_seen", {31'd0, got}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          pulses;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'd0, req_ready}, 32'd0);
    check("reset_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", {31'd0, req_ready}, 32'd1);

    // First load: latency and reset contents.
    do_req(1'b0, 32'h0000_0000, 4'hF, 32'd0, 32'h0000_1000, rd, er, lat);
    check("first_load_latency", lat, LATENCY + 1);
    check("first_load_rdata", rd, 32'h0);
    check("first_load_err", {31'd0, er}, 32'd0);

    // Full-word store, then unaligned load of the same word.
    do_req(1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 32'h0000_3000, rd, er, lat);
    check("store1_rdata", rd, 32'h0);
    do_req(1'b0, 32'h0000_0013, 4'h0, 32'd0, 32'h0000_3004, rd, er, lat);
    check("load13_rdata", rd, 32'h1234_5678);

    // Single-lane store merges into the existing word.
    do_req(1'b1, 32'h0000_0012, 4'b0100, 32'h00AB_0000, 32'h0000_3008, rd, er, lat);
    do_req(1'b0, 32'h0000_0010, 4'hF, 32'd0, 32'h0000_300C, rd, er, lat);
    check("merged_rdata", rd, 32'h12AB_5678);

    // Errors: out of range and store without lanes.
    do_req(1'b1, 32'h0000_4000, 4'hF, 32'hFFFF_FFFF, 32'h0000_3010, rd, er, lat);
    check("oob_err", {31'd0, er}, 32'd1);
    check("oob_rdata", rd, 32'h0);
    do_req(1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h0000_3014, rd, er, lat);
    check("be0_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h0000_0010, 4'hF, 32'd0, 32'h0000_3018, rd, er, lat);
    check("after_err_rdata", rd, 32'h12AB_5678);
    check("after_err_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h0000_3FFC, 4'hF, 32'd0, 32'h0000_301C, rd, er, lat);
    check("last_word_err", {31'd0, er}, 32'd0);

    // Streaming requests: valid held high, new store address every cycle.
    @(negedge clk);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
      req_addr = 32'h0000_0100 + 32'(4 * i); req_wdata = 32'(i + 1); req_pc = 32'h0000_5000;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    do_req(1'b0, 32'h0000_0100, 4'hF, 32'd0, 32'd0, rd, er, lat);
    check("stream_0x100", rd, 32'd1);
    do_req(1'b0, 32'h0000_0104, 4'hF, 32'd0, 32'd0, rd, er, lat);
    check("stream_0x104", rd, 32'd0);
    do_req(1'b0, 32'h0000_0110, 4'hF, 32'd0, 32'd0, rd, er, lat);
    check("stream_0x110", rd, 32'd5);
    do_req(1'b0, 32'h0000_0120, 4'hF, 32'd0, 32'd0, rd, er, lat);
    check("stream_0x120", rd, 32'd9);
    do_req(1'b0, 32'h0000_012C, 4'hF, 32'd0, 32'd0, rd, er, lat);
    check("stream_0x12c", rd, 32'd0);

    // Reset one cycle into BUSY abandons the store.
    @(negedge clk);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
    req_addr = 32'h0000_0020; req_wdata = 32'hDEAD_BEEF; req_pc = 32'h0000_6000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("abandoned_pulses", pulses, 0);
    do_req(1'b0, 32'h0000_0020, 4'hF, 32'd0, 32'd0, rd, er, lat);
    check("abandoned_store_rdata", rd, 32'h0);
    do_req(1'b0, 32'h0000_0010, 4'hF, 32'd0, 32'd0, rd, er, lat);
    check("reset_cleared_rdata", rd, 32'h0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the pipelined CPU's M-stage load/store path: the slave end of the request/response memory interface.
- Accepts one word-addressed request per handshake, with byte enables.
- Performs the read or the byte-masked write after a fixed, parameterised latency.
- Returns read data or an error flag. Lets the team model multi-cycle memory that the CPU must stall on.

Parameters:
- ADDR_W, 12, word-index width; capacity 2^ADDR_W words (default 16 KiB).
- BASE, 32'h0000_0000, byte address of word 0.
- LATENCY, 2, edges from accept to response; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address; bits [1:0] ignored for indexing
- req_be  input  4  byte-lane enables; bit i covers wdata[8i+7:8i]
- req_wdata  input  32  store data, already lane-aligned by the CPU
- req_pc  input  32  PC of the issuing instruction, used only for the write log
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  full word read; 0 on writes and errors
- rsp_err  output  1  request rejected; valid with rsp_valid

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, counter=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All memory words cleared to 0.
  - req_ready is 0 while reset is low.
- States: IDLE, BUSY, RESP.
  - req_ready = (state==IDLE) && reset.
- IDLE:
  - Handshake at edge e0 when req_valid && req_ready.
  - Latch we/addr/be/wdata/pc.
  - Load counter with LATENCY-1 and go to BUSY.
  - Without a handshake, stay in IDLE.
- BUSY:
  - Each edge with counter!=0 decrements the counter.
  - At the edge with counter==0 (edge e_LATENCY), perform the access, register the outputs and go to RESP.
- Access at e_LATENCY:
  - Index = (addr - BASE) >> 2, 32-bit wrap-around subtraction.
  - Error if index >= 2^ADDR_W, or if we==1 and be==4'b0000.
  - Error case: no array change; rsp_err=1, rsp_rdata=0.
  - Load: rsp_rdata = mem[index], full word; be is ignored on loads.
  - Store: only lanes with be[i]=1 are updated; rsp_rdata=0.
  - Store also prints `$display("@%h: *%h <= %h", pc, addr & ~3, merged_word)`. The address printed is the aligned byte address; merged_word is the post-merge word.
- RESP:
  - rsp_valid=1 for exactly this one cycle.
  - Next edge: rsp_valid=0, rsp_err=0, state=IDLE.
  - rsp_rdata holds its value until the next response.
- Throughput: one request per LATENCY+2 cycles. No pipelining, and no acceptance in BUSY or RESP.
- Read-after-write ordering is strict: a load issued after a store's response sees the stored data.
- Requests presented while req_ready=0 are ignored, not queued. The requester must hold them until the handshake.
- Reset mid-BUSY or mid-RESP:
  - The pending request is abandoned: no write, no response pulse, no display line.
  - All reset values apply.
- X-safety: req_* are sampled only on the handshake edge; other-cycle values have no effect.

Test Plan:
- Reset, release; load 0x0000_0000 → req_ready=1; with LATENCY=2, rsp_valid pulses in the cycle after the 2nd edge following accept; rsp_rdata=0x0, rsp_err=0; req_ready low for 3 cycles.
- Store 0x12345678, be=1111, addr 0x10, pc 0x0000_3000 → log "@00003000: *00000010 <= 12345678"; subsequent load 0x13 → rsp_rdata=0x12345678.
- Store 0x00AB0000, be=0100, addr 0x12, over the previous word → log "<= 12ab5678"; load 0x10 → 0x12AB5678.
- Hold req_valid high continuously with a new address each cycle → handshakes only in IDLE cycles; exactly one rsp_valid per handshake; unaccepted addresses never reach memory.
- Error cases:
  - Store to 0x0000_4000 (ADDR_W=12) → rsp_err=1, rsp_rdata=0, no log.
  - Store be=0000 to 0x10 → rsp_err=1.
  - Load 0x10 afterwards still returns 0x12AB5678.
- Accept store 0xDEADBEEF to 0x20, then drive reset=0 one cycle into BUSY → no rsp_valid, no log; after release, load 0x20 → 0x0.
